dmem_lsu: RTL and testbench

- Data-memory responder that sits on the far side of the pipeline's memory-stage interface.
- Consumes the M-stage address (ALUResultM), store data (BM), control and funct3; returns load data as ReadDataM.
- Performs byte/half/word access with alignment checking and load sign/zero extension.
- Models a multi-cycle memory with programmable wait states and asserts StallM so the hazard unit freezes the pipeline until the response is ready.

---
 rtl/dmem_lsu_pkg.sv | 21 ++
 rtl/dmem_lsu_align.sv | 63 ++++++
 rtl/dmem_lsu.sv | 115 +++++++++++
 tb/tb_dmem_lsu.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_lsu_pkg.sv
// Shared definitions for the data-memory load/store unit: funct3 codes,
// FSM state encoding and the wait-state counter width.
package dmem_lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Wait states are limited to 0..15.
  localparam int WS_W = 4;
  typedef logic [WS_W-1:0] cnt_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/dmem_lsu_align.sv
// lsu_align: combinational legality/alignment check, store lane steering and
// load lane select with sign/zero extension; zero latency, no flow control.
module lsu_align
  import dmem_lsu_pkg::*;
(
  input  logic        is_store,
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic        err,
  output logic [3:0]  be,
  output logic [31:0] wlane,
  output logic [31:0] rext
);

  logic        legal;
  logic        aligned;
  logic [7:0]  bsel;
  logic [15:0] hsel;

  always_comb begin
    legal   = 1'b0;
    aligned = 1'b1;
    case (funct3)
      F3_B:  legal = 1'b1;
      F3_H:  begin legal = 1'b1;      aligned = ~addr_lo[0];         end
      F3_W:  begin legal = 1'b1;      aligned = (addr_lo == 2'b00);  end
      F3_BU: legal = ~is_store;
      F3_HU: begin legal = ~is_store; aligned = ~addr_lo[0];         end
      default: legal = 1'b0;
    endcase
    err = ~legal | ~aligned;
  end

  // Store data is replicated across lanes so the byte enables alone pick the target.
  always_comb begin
    be    = 4'b0000;
    wlane = wdata;
    case (funct3)
      F3_B: begin be = 4'b0001 << addr_lo;               wlane = {4{wdata[7:0]}};  end
      F3_H: begin be = addr_lo[1] ? 4'b1100 : 4'b0011;   wlane = {2{wdata[15:0]}}; end
      F3_W: be = 4'b1111;
      default: be = 4'b0000;
    endcase
  end

  assign bsel = rword[{addr_lo, 3'b000} +: 8];
  assign hsel = addr_lo[1] ? rword[31:16] : rword[15:0];

  always_comb begin
    rext = '0;
    case (funct3)
      F3_B:  rext = {{24{bsel[7]}}, bsel};
      F3_BU: rext = {24'h000000, bsel};
      F3_H:  rext = {{16{hsel[15]}}, hsel};
      F3_HU: rext = {16'h0000, hsel};
      F3_W:  rext = rword;
      default: rext = '0;
    endcase
  end

endmodule

// File: rtl/dmem_lsu.sv
// dmem_lsu: multi-cycle data-memory responder; StallM held WAIT_STATES+2 cycles,
// load data valid in the RESP cycle; StallM freezes the pipeline until then.
module dmem_lsu
  import dmem_lsu_pkg::*;
#(
  parameter int DEPTH       = 1024,
  parameter int WAIT_STATES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MemReadM,
  input  logic        MemWriteM,
  input  logic [2:0]  Funct3M,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] BM,
  output logic [31:0] ReadDataM,
  output logic        StallM,
  output logic        MemErrM
);

  localparam int AW = $clog2(DEPTH);

  state_t        state, state_nxt;
  cnt_t          cnt, cnt_nxt;
  logic [31:0]   rdata, rdata_nxt;
  logic [31:0]   ram [DEPTH];

  logic [AW-1:0] idx;
  logic          req;
  logic          acc_err;
  logic          commit;
  logic          we;
  logic [3:0]    be;
  logic [31:0]   wlane;
  logic [31:0]   rext;
  logic          unused_hi;

  // Upper address bits alias onto the array.
  assign idx       = ALUResultM[AW+1:2];
  assign unused_hi = ^ALUResultM[31:AW+2];
  assign req       = MemReadM | MemWriteM;

  lsu_align u_align (
    .is_store (MemWriteM),
    .funct3   (Funct3M),
    .addr_lo  (ALUResultM[1:0]),
    .wdata    (BM),
    .rword    (ram[idx]),
    .err      (acc_err),
    .be       (be),
    .wlane    (wlane),
    .rext     (rext)
  );

  assign commit = (state == WAIT) && (cnt == '0);
  // A reset landing on the commit edge must not let the store through.
  assign we     = commit && MemWriteM && !acc_err && rst;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    rdata_nxt = rdata;
    StallM    = 1'b0;
    MemErrM   = 1'b0;
    ReadDataM = '0;
    case (state)
      IDLE: begin
        if (req) begin
          if (acc_err) begin
            MemErrM = 1'b1;
          end else begin
            StallM    = 1'b1;
            state_nxt = WAIT;
            cnt_nxt   = cnt_t'(WAIT_STATES);
          end
        end
      end
      WAIT: begin
        StallM = 1'b1;
        if (cnt != '0) begin
          cnt_nxt = cnt - cnt_t'(1);
        end else begin
          state_nxt = RESP;
          rdata_nxt = MemWriteM ? 32'h0 : rext;
        end
      end
      RESP: begin
        ReadDataM = rdata;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
      rdata <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      rdata <= rdata_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) ram[idx][8*i +: 8] <= wlane[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dmem_lsu.sv
// Bench for dmem_lsu: directed scenarios plus randomized accesses checked
// against a byte-addressed reference memory; two instances (2 and 0 wait states).
`timescale 1ns/1ps
module tb_dmem_lsu;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        mr  [2];
  logic        mw  [2];
  logic [2:0]  f3s [2];
  logic [31:0] adr [2];
  logic [31:0] bm  [2];
  logic [31:0] rdd [2];
  logic        stl [2];
  logic        er  [2];

  int checks = 0;
  int errors = 0;

  logic [7:0] mref [2][4096];

  always #5 clk = ~clk;

  dmem_lsu #(.DEPTH(1024), .WAIT_STATES(2)) dut (
    .clk(clk), .rst(rst), .MemReadM(mr[0]), .MemWriteM(mw[0]), .Funct3M(f3s[0]),
    .ALUResultM(adr[0]), .BM(bm[0]), .ReadDataM(rdd[0]), .StallM(stl[0]), .MemErrM(er[0])
  );

  dmem_lsu #(.DEPTH(1024), .WAIT_STATES(0)) dut_ws0 (
    .clk(clk), .rst(rst), .MemReadM(mr[1]), .MemWriteM(mw[1]), .Funct3M(f3s[1]),
    .ALUResultM(adr[1]), .BM(bm[1]), .ReadDataM(rdd[1]), .StallM(stl[1]), .MemErrM(er[1])
  );

  function automatic int ws(input int s);
    return (s == 0) ? 2 : 0;
  endfunction

  function automatic bit legal(input logic wr, input logic [2:0] f3, input logic [31:0] a);
    int sz;
    if (wr) begin
      if (f3 > 3'd2) return 1'b0;
    end else if (f3 == 3'd3 || f3 > 3'd5) begin
      return 1'b0;
    end
    sz = 1 << f3[1:0];
    return (int'(a[1:0]) % sz) == 0;
  endfunction

  function automatic logic [31:0] ref_load(input int s, input logic [2:0] f3, input logic [31:0] a);
    int sz;
    int base;
    logic [31:0] v;
    sz   = 1 << f3[1:0];
    base = int'(a[11:0]);
    v    = '0;
    for (int i = 0; i < sz; i++) v = v | ({24'h0, mref[s][base+i]} << (8*i));
    if (!f3[2] && sz < 4 && v[8*sz-1]) v = v | (32'hFFFFFFFF << (8*sz));
    return v;
  endfunction

  task automatic ref_store(input int s, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
    int sz;
    int base;
    sz   = 1 << f3[1:0];
    base = int'(a[11:0]);
    for (int i = 0; i < sz; i++) mref[s][base+i] = d[8*i +: 8];
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs(input int s);
    mr[s] = 1'b0; mw[s] = 1'b0; f3s[s] = 3'b000; adr[s] = '0; bm[s] = '0;
  endtask

  // Entered and left at posedge+1; samples every cycle on the falling edge.
  task automatic access(input int s, input logic rd, input logic wr, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] d,
                        output logic [31:0] rdo, output int stalls, output logic errs);
    mr[s] = rd; mw[s] = wr; f3s[s] = f3; adr[s] = a; bm[s] = d;
    stalls = 0; errs = 1'b0; rdo = '0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (er[s]) errs = 1'b1;
      if (stl[s] === 1'b1) begin
        stalls++;
      end else begin
        rdo = rdd[s];
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    clear_inputs(s);
  endtask

  task automatic run(input int s, input logic rd, input logic wr, input logic [2:0] f3,
                     input logic [31:0] a, input logic [31:0] d, input string tag,
                     output logic [31:0] rdo);
    bit ok;
    logic [31:0] exp;
    int stalls;
    logic errs;
    ok  = legal(wr, f3, a);
    exp = (ok && !wr) ? ref_load(s, f3, a) : 32'h0;
    access(s, rd, wr, f3, a, d, rdo, stalls, errs);
    chk({tag, " data"}, rdo, exp);
    chk({tag, " stall"}, 32'(stalls), ok ? 32'(ws(s) + 2) : 32'h0);
    chk({tag, " err"}, {31'h0, errs}, {31'h0, !ok});
    if (ok && wr) ref_store(s, f3, a, d);
  endtask

  initial begin
    logic [31:0] r;
    logic [31:0] a;
    logic [2:0]  f;
    int          k;

    for (int s = 0; s < 2; s++) begin
      clear_inputs(s);
      for (int i = 0; i < 4096; i++) mref[s][i] = 8'h00;
    end

    // Reset state
    rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      chk("reset stall", {31'h0, stl[s]}, 32'h0);
      chk("reset err",   {31'h0, er[s]},  32'h0);
      chk("reset rdata", rdd[s], 32'h0);
    end
    @(posedge clk); #1;
    rst = 1'b1;

    // Word store/load round trip
    run(0, 1'b0, 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, "t1 sw", r);
    run(0, 1'b1, 1'b0, 3'b010, 32'h10, 32'h0, "t1 lw", r);
    chk("t1 lw value", r, 32'hDEADBEEF);

    // Byte store and sub-word loads
    run(0, 1'b0, 1'b1, 3'b000, 32'h13, 32'h00000080, "t2 sb", r);
    run(0, 1'b1, 1'b0, 3'b000, 32'h13, 32'h0, "t2 lb", r);
    chk("t2 lb value", r, 32'hFFFFFF80);
    run(0, 1'b1, 1'b0, 3'b100, 32'h13, 32'h0, "t2 lbu", r);
    chk("t2 lbu value", r, 32'h00000080);
    run(0, 1'b1, 1'b0, 3'b010, 32'h10, 32'h0, "t2 lw", r);
    chk("t2 lw value", r, 32'h80ADBEEF);
    run(0, 1'b1, 1'b0, 3'b001, 32'h12, 32'h0, "t2 lh", r);
    chk("t2 lh value", r, 32'hFFFF80AD);

    // Misaligned requests held for several cycles never leave IDLE
    mw[0] = 1'b1; f3s[0] = 3'b001; adr[0] = 32'h11; bm[0] = 32'hFFFFFFFF;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t3 sh err",   {31'h0, er[0]},  32'h1);
      chk("t3 sh stall", {31'h0, stl[0]}, 32'h0);
      chk("t3 sh rdata", rdd[0], 32'h0);
      @(posedge clk); #1;
    end
    clear_inputs(0);
    run(0, 1'b1, 1'b0, 3'b010, 32'h12, 32'h0, "t3 lw misaligned", r);
    run(0, 1'b1, 1'b0, 3'b010, 32'h10, 32'h0, "t3 lw after", r);
    chk("t3 lw value", r, 32'h80ADBEEF);

    // Reset during the second WAIT cycle aborts the store
    run(0, 1'b0, 1'b1, 3'b010, 32'h20, 32'h00000000, "t4 sw zero", r);
    mw[0] = 1'b1; f3s[0] = 3'b010; adr[0] = 32'h20; bm[0] = 32'h12345678;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    clear_inputs(0);
    @(negedge clk);
    chk("t4 abort stall", {31'h0, stl[0]}, 32'h0);
    chk("t4 abort err",   {31'h0, er[0]},  32'h0);
    chk("t4 abort rdata", rdd[0], 32'h0);
    @(posedge clk); #1;
    run(0, 1'b1, 1'b0, 3'b010, 32'h20, 32'h0, "t4 lw", r);
    chk("t4 lw value", r, 32'h00000000);

    // Reset coinciding with the commit edge suppresses the write
    run(0, 1'b0, 1'b1, 3'b010, 32'h28, 32'h5555AAAA, "t4b sw", r);
    mw[0] = 1'b1; f3s[0] = 3'b010; adr[0] = 32'h28; bm[0] = 32'h11111111;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    clear_inputs(0);
    run(0, 1'b1, 1'b0, 3'b010, 32'h28, 32'h0, "t4b lw", r);
    chk("t4b lw value", r, 32'h5555AAAA);

    // Read and write together: write wins, no load data returned
    run(0, 1'b1, 1'b1, 3'b010, 32'h24, 32'hCAFEF00D, "t5 rw", r);
    run(0, 1'b1, 1'b0, 3'b010, 32'h24, 32'h0, "t5 lw", r);
    chk("t5 lw value", r, 32'hCAFEF00D);

    // Zero-wait-state instance
    run(1, 1'b0, 1'b1, 3'b010, 32'h10, 32'h0BADC0DE, "t6 sw", r);
    run(1, 1'b1, 1'b0, 3'b010, 32'h10, 32'h0, "t6 lw", r);
    chk("t6 lw value", r, 32'h0BADC0DE);
    run(1, 1'b1, 1'b0, 3'b011, 32'h10, 32'h0, "t6 illegal f3", r);

    // Randomized accesses over a preloaded window, with address aliasing
    for (int i = 0; i < 16; i++)
      run(0, 1'b0, 1'b1, 3'b010, 32'h100 + 32'(4*i), $urandom, "pre sw", r);
    for (int i = 0; i < 80; i++) begin
      a = 32'h100 + 32'($urandom_range(0, 63));
      if ($urandom_range(0, 3) == 0) a = a | ($urandom << 12);
      f = 3'($urandom_range(0, 7));
      k = $urandom_range(0, 3);
      run(0, (k != 1), (k == 1 || k == 2), f, a, $urandom, "rnd", r);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
